// File: rtl/rv_instr_encoder_loader.sv
// RV32I field-bundle encoder and sequential instruction-memory loader.
// Optional immediate range checking is enabled by defining ENCODER_IMM_CHECK_EN.
module rv_instr_encoder_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [2:0]            kind,
  input  logic [2:0]            func3,
  input  logic                  func7b5,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [31:0]           imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  done,
  output logic                  overflow,
  output logic                  err_illegal
);

  localparam logic [2:0] K_R = 3'd0, K_I = 3'd1, K_LOAD = 3'd2, K_STORE = 3'd3,
                         K_BRANCH = 3'd4, K_LUI = 3'd5, K_JAL = 3'd6, K_JALR = 3'd7;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state, state_n;

  logic accept;
  logic legal;

  function automatic logic [31:0] encode(
    input logic [2:0] k, input logic [2:0] f3, input logic f7,
    input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
    input logic [31:0] im);
    logic [31:0] w;
    w = 32'd0;
    case (k)
      K_R:      w = {1'b0, f7, 5'b0, s2, s1, f3, d, 7'b0110011};
      K_I:
        // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt
        if (f3 == 3'b001 || f3 == 3'b101)
          w = {1'b0, f7, 5'b0, im[4:0], s1, f3, d, 7'b0010011};
        else
          w = {im[11:0], s1, f3, d, 7'b0010011};
      K_LOAD:   w = {im[11:0], s1, f3, d, 7'b0000011};
      K_STORE:  w = {im[11:5], s2, s1, f3, im[4:0], 7'b0100011};
      K_BRANCH: w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'b1100011};
      K_LUI:    w = {im[31:12], d, 7'b0110111};
      K_JAL:    w = {im[20], im[10:1], im[11], im[19:12], d, 7'b1101111};
      K_JALR:   w = {im[11:0], s1, 3'b000, d, 7'b1100111};
      default:  w = 32'd0;
    endcase
    return w;
  endfunction

  assign in_ready = (state == LOAD) && (count < DEPTH_C);
  assign accept   = in_valid && in_ready;

`ifdef ENCODER_IMM_CHECK_EN
  function automatic logic imm_legal(input logic [2:0] k, input logic [31:0] im);
    logic ok;
    ok = 1'b1;
    case (k)
      K_I, K_LOAD, K_STORE, K_JALR: ok = (&im[31:11]) || !(|im[31:11]);
      K_BRANCH: ok = ((&im[31:12]) || !(|im[31:12])) && !im[0];
      K_JAL:    ok = ((&im[31:20]) || !(|im[31:20])) && !im[0];
      K_LUI:    ok = !(|im[11:0]);
      default:  ok = 1'b1;
    endcase
    return ok;
  endfunction

  assign legal = imm_legal(kind, imm);

  always_ff @(posedge clk) begin
    if (rst || start)
      err_illegal <= 1'b0;
    else if (accept && !legal)
      err_illegal <= 1'b1;
  end
`else
  assign legal       = 1'b1;
  assign err_illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = LOAD;
      LOAD:    if (start) state_n = LOAD;
               else if (accept && in_last) state_n = DONE;
      DONE:    if (start) state_n = LOAD;
      default: state_n = IDLE;
    endcase
  end

  // Write stage: the accepting edge launches the write and advances count
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      count     <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (start) begin
        count    <= '0;
        done     <= 1'b0;
        overflow <= 1'b0;
      end else if (accept) begin
        if (legal) begin
          mem_we    <= 1'b1;
          mem_addr  <= count[ADDR_WIDTH-1:0];
          mem_wdata <= encode(kind, func3, func7b5, rd, rs1, rs2, imm);
          count     <= count + 1'b1;
        end
        if (in_last) done <= 1'b1;
      end else if (state == LOAD && in_valid) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder_loader.sv
// Scoreboard bench for rv_instr_encoder_loader (DEPTH=4 so the full case is reachable).
module tb_rv_instr_encoder_loader;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_last, func7b5;
  logic [2:0]    kind, func3;
  logic [4:0]    rd, rs1, rs2;
  logic [31:0]   imm;
  logic          in_ready, mem_we, done, overflow, err_illegal;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
  wr_t sb_q[$];

  rv_instr_encoder_loader #(.ADDR_WIDTH(AW), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .kind(kind), .func3(func3), .func7b5(func7b5), .rd(rd),
    .rs1(rs1), .rs2(rs2), .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .count(count), .done(done), .overflow(overflow),
    .err_illegal(err_illegal));

  always #5 clk = ~clk;

  // Monitor: every write the DUT presents is matched against the scoreboard
  always @(negedge clk) begin
    if (mem_we) begin
      wr_t e;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, none expected", mem_addr, mem_wdata);
      end else begin
        e = sb_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive one bundle for one cycle; expected write is pushed when push=1
  task automatic send(input logic [2:0] k, input logic [2:0] f3, input logic f7,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] im, input logic last, input logic push,
                      input logic [AW-1:0] a, input logic [31:0] w);
    kind = k; func3 = f3; func7b5 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_last = last; in_valid = 1'b1;
    if (push) sb_q.push_back('{addr: a, data: w});
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    kind = 3'd0; func3 = 3'd0; func7b5 = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd0;
    tick(); tick();
    check("reset_count", 32'(count), 32'd0);
    check("reset_flags", {28'd0, done, overflow, err_illegal, mem_we}, 32'd0);
    check("reset_ready", 32'(in_ready), 32'd0);
    rst = 1'b0; tick();

    // add x3,x1,x2
    do_start();
    check("ready_after_start", 32'(in_ready), 32'd1);
    send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 8'd0, 32'h002081B3);
    check("count_after_add", 32'(count), 32'd1);
    tick();

    // addi / sw / lui back-to-back
    do_start();
    check("count_cleared", 32'(count), 32'd0);
    send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,        1'b0, 1'b1, 8'd0, 32'h00500093);
    send(3'd3, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,        1'b0, 1'b1, 8'd1, 32'h0020A423);
    send(3'd5, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 1'b1, 8'd2, 32'h123452B7);
    check("done_after_lui", 32'(done), 32'd1);
    check("count_after_lui", 32'(count), 32'd3);
    check("ready_in_done", 32'(in_ready), 32'd0);
    tick();

    // beq x1,x2,-4 ; jal x1,8
    do_start();
    check("done_cleared", 32'(done), 32'd0);
    send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0, 1'b1, 8'd0, 32'hFE208EE3);
    send(3'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,        1'b1, 1'b1, 8'd1, 32'h008000EF);
    check("done_after_jal", 32'(done), 32'd1);
    tick();

    // Fill to DEPTH=4 and keep offering: sub, srai, jalr, lw
    do_start();
    send(3'd0, 3'd0, 1'b1, 5'd4, 5'd5, 5'd6, 32'd0, 1'b0, 1'b1, 8'd0, 32'h40628233);
    send(3'd1, 3'd5, 1'b1, 5'd7, 5'd7, 5'd0, 32'd3, 1'b0, 1'b1, 8'd1, 32'h4033D393);
    send(3'd7, 3'd5, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0, 1'b0, 1'b1, 8'd2, 32'h00008067);
    send(3'd2, 3'd2, 1'b0, 5'd8, 5'd2, 5'd0, 32'hFFFFFFFC, 1'b0, 1'b1, 8'd3, 32'hFFC12403);
    check("ready_when_full", 32'(in_ready), 32'd0);
    send(3'd0, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1, 1'b0, 8'd0, 32'd0);
    check("overflow_set", 32'(overflow), 32'd1);
    check("done_not_set_full", 32'(done), 32'd0);
    check("count_full", 32'(count), 32'd4);
    tick();
    check("overflow_sticky", 32'(overflow), 32'd1);

    // start with a same-cycle bundle mid-load discards it
    do_start();
    check("overflow_cleared", 32'(overflow), 32'd0);
    send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 1'b1, 8'd0, 32'h00100093);
    start = 1'b1;
    send(3'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0, 1'b0, 8'd0, 32'd0);
    start = 1'b0;
    check("restart_count", 32'(count), 32'd0);
    check("restart_no_write", 32'(mem_we), 32'd0);
    send(3'd1, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd3, 1'b0, 1'b1, 8'd0, 32'h00300193);
    check("restart_next_count", 32'(count), 32'd1);
    tick();

    // addi x1,x0,0x800: out of I range
    do_start();
`ifdef ENCODER_IMM_CHECK_EN
    send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h800, 1'b1, 1'b0, 8'd0, 32'd0);
    check("illegal_count", 32'(count), 32'd0);
    check("illegal_err", 32'(err_illegal), 32'd1);
    check("illegal_done", 32'(done), 32'd1);
`else
    send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h800, 1'b1, 1'b1, 8'd0, 32'h80000093);
    check("trunc_count", 32'(count), 32'd1);
    check("trunc_err", 32'(err_illegal), 32'd0);
`endif
    tick(); tick();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
